// File: rtl/line_buffer_3row_if.sv
// Pixel-in / column-out bus of the three-row line buffer.
// Handshake: a pixel moves on a rising clk edge where pix_valid and pix_ready
// are both 1; a column is popped on a rising clk edge where col_valid and
// shift_buffer are both 1. Neither side may make valid depend on ready.
interface line_buffer_3row_if #(
  parameter int BIT_DEPTH = 8
);
  logic                 start;
  logic [BIT_DEPTH-1:0] pix_in;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 shift_buffer;
  logic [BIT_DEPTH-1:0] in_l1;
  logic [BIT_DEPTH-1:0] in_l2;
  logic [BIT_DEPTH-1:0] in_l3;
  logic                 col_valid;
  logic                 row_done;
  logic                 done;

  // Producer/consumer side (stimulus or upstream + convolution stage)
  modport master (
    output start, pix_in, pix_valid, shift_buffer,
    input  pix_ready, in_l1, in_l2, in_l3, col_valid, row_done, done
  );

  // Line buffer side
  modport slave (
    input  start, pix_in, pix_valid, shift_buffer,
    output pix_ready, in_l1, in_l2, in_l3, col_valid, row_done, done
  );
endinterface

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: stores rows in three rotating flop banks and presents
// one vertically aligned top/mid/bottom column per pop.
module line_buffer_3row #(
  parameter int BIT_DEPTH  = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int COL_W      = 5,
  parameter int ROW_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  line_buffer_3row_if.slave     bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_READ   = 3'd2,
    S_REFILL = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [BIT_DEPTH-1:0] bank [3][IMG_WIDTH];
  logic [1:0]           wr_bank;
  logic [1:0]           top_ptr;
  logic [1:0]           rows_in;
  logic [COL_W-1:0]     wr_col;
  logic [COL_W-1:0]     rd_col;
  logic [ROW_W-1:0]     out_row;

  logic accept, row_in_last, pop, pop_last, last_out_row;
  logic [1:0] mid_ptr, bot_ptr;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign mid_ptr      = ptr_inc(top_ptr);
  assign bot_ptr      = ptr_inc(mid_ptr);
  assign accept       = bus.pix_valid & bus.pix_ready;
  assign row_in_last  = accept && (wr_col == COL_W'(IMG_WIDTH - 1));
  assign pop          = (state == S_READ) && bus.shift_buffer;
  assign pop_last     = pop && (rd_col == COL_W'(IMG_WIDTH - 1));
  assign last_out_row = (out_row == ROW_W'(IMG_HEIGHT - 3));
  assign dbg_state    = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_FILL;
      S_FILL:   if (row_in_last && rows_in == 2'd2) state_nxt = S_READ;
      S_READ:   if (pop_last) state_nxt = last_out_row ? S_DONE : S_REFILL;
      S_REFILL: if (row_in_last) state_nxt = S_READ;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs: handshake flags and the column taken from the rotated banks
  always_comb begin
    bus.pix_ready = (state == S_FILL) || (state == S_REFILL);
    bus.col_valid = (state == S_READ);
    bus.row_done  = pop_last;
    bus.done      = (state == S_DONE);
    bus.in_l1     = '0;
    bus.in_l2     = '0;
    bus.in_l3     = '0;
    if (state == S_READ) begin
      bus.in_l1 = bank[top_ptr][rd_col];
      bus.in_l2 = bank[mid_ptr][rd_col];
      bus.in_l3 = bank[bot_ptr][rd_col];
    end
  end

  // Counters, bank rotation and pixel writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= '0;
      top_ptr <= '0;
      rows_in <= '0;
      wr_col  <= '0;
      rd_col  <= '0;
      out_row <= '0;
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < IMG_WIDTH; c++)
          bank[b][c] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            wr_bank <= '0;
            top_ptr <= '0;
            rows_in <= '0;
            wr_col  <= '0;
            rd_col  <= '0;
            out_row <= '0;
          end
        end
        S_FILL, S_REFILL: begin
          if (accept) begin
            bank[wr_bank][wr_col] <= bus.pix_in;
            if (row_in_last) begin
              wr_col <= '0;
              // Initial fill walks banks 0,1,2; a refill stays on its one bank
              if (state == S_FILL && rows_in != 2'd2) begin
                rows_in <= rows_in + 2'd1;
                wr_bank <= wr_bank + 2'd1;
              end
            end else begin
              wr_col <= wr_col + COL_W'(1);
            end
          end
        end
        S_READ: begin
          if (pop_last) begin
            rd_col  <= '0;
            out_row <= out_row + ROW_W'(1);
            if (!last_out_row) begin
              // Oldest row is retired: it becomes the write target, and the
              // former middle row becomes the new top
              wr_bank <= top_ptr;
              top_ptr <= mid_ptr;
            end
          end else if (pop) begin
            rd_col <= rd_col + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row with a 4x5 image; pixel k carries value k.
module tb_line_buffer_3row;
  localparam int BD = 8;
  localparam int W  = 4;
  localparam int H  = 5;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FILL = 3'd1, ST_READ = 3'd2,
                         ST_REFILL = 3'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  line_buffer_3row_if #(.BIT_DEPTH(BD)) bus ();

  line_buffer_3row #(
    .BIT_DEPTH(BD), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(2), .ROW_W(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Expected columns of one frame: {row_done, top, mid, bottom}
  typedef struct {
    logic       last;
    logic [7:0] t, m, b;
  } col_vec_t;
  col_vec_t vec [12];

  logic [3*BD:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int dn_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every popped column against the queue head
  always @(negedge clk) begin
    logic [3*BD:0] e;
    if (bus.col_valid && bus.shift_buffer) begin
      if (exp_q.size() == 0) begin
        check("column_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("column", {bus.in_l1, bus.in_l2, bus.in_l3}, e[3*BD-1:0]);
        check("row_done", bus.row_done, e[3*BD]);
        check("pix_ready_in_read", bus.pix_ready, 0);
      end
    end else if (bus.row_done) begin
      check("row_done_spurious", 1, 0);
    end
    if (bus.row_done) rd_cnt++;
    if (bus.done) dn_cnt++;
  end

  task automatic start_frame();
    exp_q.delete();
    rd_cnt = 0;
    dn_cnt = 0;
    foreach (vec[i]) exp_q.push_back({vec[i].last, vec[i].t, vec[i].m, vec[i].b});
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Drive one pixel, optionally after random idle cycles; returns #1 after the accepting edge
  task automatic send_pix(input int v, input int gap_pct);
    int budget = 1000;
    while ($urandom_range(99) < gap_pct) begin
      bus.pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.pix_in    = 8'(v);
    bus.pix_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.pix_ready) break;
      budget--;
      if (budget == 0) break;
    end
    if (budget == 0) check("pix_accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input int gap_pct);
    for (int k = first; k <= last; k++) send_pix(k, gap_pct);
  endtask

  // Pop until the scoreboard drains; shift may also be asserted while col_valid=0
  task automatic consume(input int gap_pct);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      bus.shift_buffer = ($urandom_range(99) >= gap_pct);
      @(posedge clk); #1;
      cyc++;
    end
    bus.shift_buffer = 1'b0;
    check("consume_drained", exp_q.size(), 0);
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 10 && dn_cnt == 0; i++) @(negedge clk);
    check("done_pulses", dn_cnt, 1);
    check("row_done_pulses", rd_cnt, H - 2);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("back_to_idle", dbg_state, ST_IDLE);
    check("done_count_final", dn_cnt, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_ready"}, bus.pix_ready, 0);
    check({tag, "_col_valid"}, bus.col_valid, 0);
    check({tag, "_row_done"}, bus.row_done, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_cols"}, {bus.in_l1, bus.in_l2, bus.in_l3}, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    vec[0]  = '{1'b0, 8'd0,  8'd4,  8'd8};
    vec[1]  = '{1'b0, 8'd1,  8'd5,  8'd9};
    vec[2]  = '{1'b0, 8'd2,  8'd6,  8'd10};
    vec[3]  = '{1'b1, 8'd3,  8'd7,  8'd11};
    vec[4]  = '{1'b0, 8'd4,  8'd8,  8'd12};
    vec[5]  = '{1'b0, 8'd5,  8'd9,  8'd13};
    vec[6]  = '{1'b0, 8'd6,  8'd10, 8'd14};
    vec[7]  = '{1'b1, 8'd7,  8'd11, 8'd15};
    vec[8]  = '{1'b0, 8'd8,  8'd12, 8'd16};
    vec[9]  = '{1'b0, 8'd9,  8'd13, 8'd17};
    vec[10] = '{1'b0, 8'd10, 8'd14, 8'd18};
    vec[11] = '{1'b1, 8'd11, 8'd15, 8'd19};

    bus.start = 1'b0;
    bus.pix_in = '0;
    bus.pix_valid = 1'b0;
    bus.shift_buffer = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Frame A: fill latency, start ignored in READ, shift held high, full frame
    start_frame();
    check("fill_state", dbg_state, ST_FILL);
    check("fill_ready", bus.pix_ready, 1);
    feed(0, 10, 0);
    check("pre_latency_col_valid", bus.col_valid, 0);
    feed(11, 11, 0);
    check("latency_col_valid", bus.col_valid, 1);
    check("first_column", {bus.in_l1, bus.in_l2, bus.in_l3}, {8'd0, 8'd4, 8'd8});
    check("read_not_ready", bus.pix_ready, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_in_read_state", dbg_state, ST_READ);
    check("start_in_read_column", {bus.in_l1, bus.in_l2, bus.in_l3}, {8'd0, 8'd4, 8'd8});
    fork
      feed(12, 19, 0);
      consume(0);
    join
    finish_frame();

    // Frame B: random pixel and shift gaps, shifts also land during FILL/REFILL
    start_frame();
    fork
      feed(0, 19, 30);
      consume(40);
    join
    finish_frame();

    // Frame C: reset asserted part-way through a refill
    start_frame();
    feed(0, 11, 0);
    bus.shift_buffer = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.shift_buffer = 1'b0;
    check("refill_state", dbg_state, ST_REFILL);
    check("refill_col_valid", bus.col_valid, 0);
    check("refill_rows_done", rd_cnt, 1);
    feed(12, 13, 0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Frame D: clean frame after reset, random gaps
    start_frame();
    fork
      feed(0, 19, 20);
      consume(25);
    join
    finish_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
